// File: rtl/fir_seq_ctrl_if.sv
// Sample handshake, coefficient write port and filter output bundle
// for the time-multiplexed FIR engine.
interface fir_seq_ctrl_if #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int CW = 16
);
    localparam int LW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 coef_we;
    logic [LW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy;

    modport master (
        output in_valid,
        output in_data,
        output coef_we,
        output coef_addr,
        output coef_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  coef_we,
        input  coef_addr,
        input  coef_data,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequenced Q1.15 FIR: one shared MAC walks all taps per accepted
// sample, then a floor shift and saturation produce the output.
module fir_seq_ctrl #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 36
) (
    input logic          clk,
    input logic          rst,
    fir_seq_ctrl_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam int PW = DW + CW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_SAT  = 2'd2;

    localparam logic [LW-1:0] LAST = LW'(N - 1);
    localparam logic [LW-1:0] ONE  = LW'(1);

    localparam logic signed [AW-1:0] SMAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    function automatic logic signed [CW-1:0] coef_init(input int i);
        case (i)
            0:       return CW'(512);
            1:       return CW'(1024);
            2:       return CW'(2048);
            3:       return CW'(4096);
            4:       return CW'(8192);
            5:       return CW'(4096);
            6:       return CW'(2048);
            7:       return CW'(1024);
            8:       return CW'(512);
            9:       return CW'(256);
            10:      return CW'(128);
            11:      return CW'(64);
            12:      return CW'(32);
            13:      return CW'(16);
            14:      return CW'(8);
            15:      return CW'(4);
            default: return '0;
        endcase
    endfunction

    logic [1:0]           r_state;
    logic signed [DW-1:0] r_hist [N];
    logic signed [CW-1:0] r_coef [N];
    logic signed [AW-1:0] r_acc;
    logic [LW-1:0]        r_wr_ptr;
    logic [LW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_tap;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_data;

    logic signed [DW-1:0] w_samp;
    logic signed [CW-1:0] w_cf;
    logic signed [PW-1:0] w_samp_x;
    logic signed [PW-1:0] w_cf_x;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_x;
    logic signed [AW-1:0] w_shift;
    logic signed [DW-1:0] w_sat;
    logic                 w_idle;

    assign w_idle   = (r_state == S_IDLE);
    assign w_samp   = r_hist[r_rd_ptr];
    assign w_cf     = r_coef[r_tap];
    assign w_samp_x = {{CW{w_samp[DW-1]}}, w_samp};
    assign w_cf_x   = {{DW{w_cf[CW-1]}}, w_cf};
    assign w_prod   = w_samp_x * w_cf_x;
    assign w_prod_x = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    // Arithmetic shift floors toward minus infinity, no rounding.
    assign w_shift  = r_acc >>> (CW - 1);

    always_comb begin
        w_sat = w_shift[DW-1:0];
        unique case (1'b1)
            (w_shift > SMAX): w_sat = SMAX[DW-1:0];
            (w_shift < SMIN): w_sat = SMIN[DW-1:0];
            default:          w_sat = w_shift[DW-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tap       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= coef_init(i);
            end
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.coef_we)
                        r_coef[bus.coef_addr] <= bus.coef_data;
                    if (bus.in_valid) begin
                        r_hist[r_wr_ptr] <= bus.in_data;
                        r_rd_ptr         <= r_wr_ptr;
                        r_tap            <= '0;
                        r_acc            <= '0;
                        r_wr_ptr         <= r_wr_ptr + ONE;
                        r_state          <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc    <= r_acc + w_prod_x;
                    r_rd_ptr <= r_rd_ptr - ONE;
                    r_tap    <= r_tap + ONE;
                    if (r_tap == LAST)
                        r_state <= S_SAT;
                end
                S_SAT: begin
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
